// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 3-stage pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2,
        FAULT = 2'd3
    } ctrl_state_t;

    // Encoding of ADDI x0,x0,0; the datapath loads this on flush and bubble.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // FAULT dominates, then a data stall, then a fetch stall.
    function automatic ctrl_state_t next_state(input logic fault,
                                               input logic timeout,
                                               input logic mem_pending,
                                               input logic imem_ack);
        if (fault || timeout)
            return FAULT;
        else if (mem_pending)
            return DWAIT;
        else if (!imem_ack)
            return IWAIT;
        else
            return RUN;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake and datapath-control bundle between pipe_ctrl and the datapath/memories.
interface pipe_ctrl_if;

    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_ack;
    logic ex_is_mem;
    logic ex_taken;
    logic pc_en;
    logic pc_sel_tgt;
    logic ifex_en;
    logic ifex_flush;
    logic exwb_bubble;
    logic ex_valid;

    modport master (
        output imem_req, dmem_req, pc_en, pc_sel_tgt, ifex_en, ifex_flush,
               exwb_bubble, ex_valid,
        input  imem_ack, dmem_ack, ex_is_mem, ex_taken
    );

    modport slave (
        input  imem_req, dmem_req, pc_en, pc_sel_tgt, ifex_en, ifex_flush,
               exwb_bubble, ex_valid,
        output imem_ack, dmem_ack, ex_is_mem, ex_taken
    );

endinterface

// File: rtl/pipe_ctrl_wait_timer.sv
// Consecutive-stall counter; expired is high once TIMEOUT-1 stalled cycles have elapsed.
module wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] wait_cnt;

    // Saturates at LAST so a frozen (faulted) pipeline never wraps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (clear)
            wait_cnt <= '0;
        else if (stall && wait_cnt != LAST)
            wait_cnt <= wait_cnt + W'(1);
    end

    assign expired = (wait_cnt == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Global advance/stall/redirect sequencing for the IF-EX-WB pipeline, with perf counters and timeout fault.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_ctrl_if.master      bus,
    output ctrl_state_t      state,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic ex_valid;
    logic dmem_done;
    logic mem_pending;
    logic advance;
    logic redirect;
    logic stall;
    logic expired;
    logic timeout;

    // A data access is outstanding until acked now or acked earlier while fetch stalled.
    assign mem_pending = ex_valid & bus.ex_is_mem & ~(bus.dmem_ack | dmem_done);
    assign advance     = bus.imem_ack & ~mem_pending & ~fault;
    assign redirect    = advance & ex_valid & bus.ex_taken;
    assign stall       = ~advance & ~fault;
    assign timeout     = expired & ~advance;

    // Fetch request is gated by rst_n so it reads low for the whole reset window.
    assign bus.imem_req    = rst_n & ~fault;
    assign bus.dmem_req    = ex_valid & bus.ex_is_mem & ~dmem_done & ~fault;
    assign bus.pc_en       = advance;
    assign bus.ifex_en     = advance;
    assign bus.pc_sel_tgt  = redirect;
    assign bus.ifex_flush  = redirect;
    assign bus.exwb_bubble = ~advance | ~ex_valid;
    assign bus.ex_valid    = ex_valid;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .clear   (advance),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            fault      <= 1'b0;
            ex_valid   <= 1'b0;
            dmem_done  <= 1'b0;
            stall_cnt  <= '0;
            retire_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            state <= next_state(fault, timeout, mem_pending, bus.imem_ack);
            if (timeout)
                fault <= 1'b1;

            // The fetched word behind a taken branch is the wrong path, so EX goes empty.
            if (advance) begin
                ex_valid  <= ~redirect;
                dmem_done <= 1'b0;
            end else if (bus.dmem_req && bus.dmem_ack) begin
                dmem_done <= 1'b1;
            end

            if (stall)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (advance && ex_valid)
                retire_cnt <= retire_cnt + CNT_W'(1);
            if (redirect)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    a_fault_quiet: assert property (@(posedge clk) disable iff (!rst_n)
        fault |-> (!bus.imem_req && !bus.dmem_req && !advance));

    a_redirect_adv: assert property (@(posedge clk) disable iff (!rst_n)
        redirect |-> advance);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with TIMEOUT=4 so the fault path is reachable quickly.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ctrl_state_t state;
    logic        fault;
    logic [31:0] stall_cnt, retire_cnt, flush_cnt;
    int          vecs = 0;
    int          errs = 0;

    pipe_ctrl_if bus();

    pipe_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .state      (state),
        .fault      (fault),
        .stall_cnt  (stall_cnt),
        .retire_cnt (retire_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.imem_ack  = 1'b0;
        bus.dmem_ack  = 1'b0;
        bus.ex_is_mem = 1'b0;
        bus.ex_taken  = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        vecs++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL rst_imem_req got %b exp 0", bus.imem_req); end
        vecs++; if (state !== RUN) begin errs++; $display("FAIL rst_state got %0d exp 0", state); end
        vecs++; if (fault !== 1'b0) begin errs++; $display("FAIL rst_fault got %b exp 0", fault); end
        vecs++; if (bus.ex_valid !== 1'b0) begin errs++; $display("FAIL rst_ex_valid got %b exp 0", bus.ex_valid); end
        vecs++; if (bus.dmem_req !== 1'b0) begin errs++; $display("FAIL rst_dmem_req got %b exp 0", bus.dmem_req); end
        vecs++; if (bus.exwb_bubble !== 1'b1) begin errs++; $display("FAIL rst_bubble got %b exp 1", bus.exwb_bubble); end
        vecs++; if ({stall_cnt, retire_cnt, flush_cnt} !== 96'd0) begin errs++; $display("FAIL rst_counters got %0d/%0d/%0d exp 0/0/0", stall_cnt, retire_cnt, flush_cnt); end
        rst_n = 1'b1;
        #1;
        vecs++; if (bus.imem_req !== 1'b1) begin errs++; $display("FAIL rel_imem_req got %b exp 1", bus.imem_req); end
        vecs++; if (bus.pc_en !== 1'b0) begin errs++; $display("FAIL rel_pc_en got %b exp 0", bus.pc_en); end
    endtask

    task automatic test_zero_wait;
        do_reset();
        bus.imem_ack = 1'b1;
        #1;
        vecs++; if (bus.pc_en !== 1'b1 || bus.ifex_en !== 1'b1) begin errs++; $display("FAIL zw_enables got %b%b exp 11", bus.pc_en, bus.ifex_en); end
        for (int i = 0; i < 6; i++) begin
            tick();
            vecs++; if (state !== RUN) begin errs++; $display("FAIL zw_state[%0d] got %0d exp 0", i, state); end
        end
        vecs++; if (retire_cnt !== 32'd5) begin errs++; $display("FAIL zw_retire got %0d exp 5", retire_cnt); end
        vecs++; if (stall_cnt !== 32'd0) begin errs++; $display("FAIL zw_stall got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_dmem_wait;
        do_reset();
        bus.imem_ack = 1'b1;
        tick();
        bus.ex_is_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if (bus.dmem_req !== 1'b1) begin errs++; $display("FAIL dw_req[%0d] got %b exp 1", i, bus.dmem_req); end
            vecs++; if (bus.exwb_bubble !== 1'b1 || bus.pc_en !== 1'b0) begin errs++; $display("FAIL dw_stall[%0d] bubble/pc_en got %b%b exp 10", i, bus.exwb_bubble, bus.pc_en); end
            tick();
            vecs++; if (state !== DWAIT) begin errs++; $display("FAIL dw_state[%0d] got %0d exp 2", i, state); end
        end
        bus.dmem_ack = 1'b1;
        #1;
        vecs++; if (bus.dmem_req !== 1'b1 || bus.pc_en !== 1'b1 || bus.exwb_bubble !== 1'b0) begin errs++; $display("FAIL dw_ack req/pc_en/bubble got %b%b%b exp 110", bus.dmem_req, bus.pc_en, bus.exwb_bubble); end
        tick();
        vecs++; if (state !== RUN) begin errs++; $display("FAIL dw_done_state got %0d exp 0", state); end
        vecs++; if (stall_cnt !== 32'd3) begin errs++; $display("FAIL dw_stall_cnt got %0d exp 3", stall_cnt); end
        vecs++; if (retire_cnt !== 32'd1) begin errs++; $display("FAIL dw_retire got %0d exp 1", retire_cnt); end
        clear_inputs();
    endtask

    task automatic test_dmem_early;
        do_reset();
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack  = 1'b0;
        bus.ex_is_mem = 1'b1;
        bus.dmem_ack  = 1'b1;
        #1;
        vecs++; if (bus.dmem_req !== 1'b1 || bus.pc_en !== 1'b0) begin errs++; $display("FAIL de_req/pc_en got %b%b exp 10", bus.dmem_req, bus.pc_en); end
        tick();
        vecs++; if (state !== IWAIT) begin errs++; $display("FAIL de_state got %0d exp 1", state); end
        bus.dmem_ack = 1'b0;
        #1;
        vecs++; if (bus.dmem_req !== 1'b0) begin errs++; $display("FAIL de_req_drop got %b exp 0", bus.dmem_req); end
        tick();
        bus.imem_ack = 1'b1;
        #1;
        vecs++; if (bus.dmem_req !== 1'b0 || bus.pc_en !== 1'b1) begin errs++; $display("FAIL de_adv req/pc_en got %b%b exp 01", bus.dmem_req, bus.pc_en); end
        tick();
        vecs++; if (retire_cnt !== 32'd1) begin errs++; $display("FAIL de_retire got %0d exp 1", retire_cnt); end
        vecs++; if (stall_cnt !== 32'd2) begin errs++; $display("FAIL de_stall got %0d exp 2", stall_cnt); end
        vecs++; if (bus.dmem_req !== 1'b1) begin errs++; $display("FAIL de_next_req got %b exp 1", bus.dmem_req); end
        clear_inputs();
    endtask

    task automatic test_branch;
        do_reset();
        bus.imem_ack = 1'b1;
        tick();
        bus.ex_taken = 1'b1;
        #1;
        vecs++; if (bus.pc_sel_tgt !== 1'b1 || bus.ifex_flush !== 1'b1) begin errs++; $display("FAIL br_redirect got %b%b exp 11", bus.pc_sel_tgt, bus.ifex_flush); end
        vecs++; if (bus.pc_en !== 1'b1 || bus.exwb_bubble !== 1'b0) begin errs++; $display("FAIL br_adv pc_en/bubble got %b%b exp 10", bus.pc_en, bus.exwb_bubble); end
        tick();
        bus.ex_taken = 1'b0;
        vecs++; if (bus.ex_valid !== 1'b0) begin errs++; $display("FAIL br_ex_valid got %b exp 0", bus.ex_valid); end
        vecs++; if (flush_cnt !== 32'd1) begin errs++; $display("FAIL br_flush_cnt got %0d exp 1", flush_cnt); end
        #1;
        vecs++; if (bus.pc_sel_tgt !== 1'b0 || bus.exwb_bubble !== 1'b1) begin errs++; $display("FAIL br_bubble sel/bubble got %b%b exp 01", bus.pc_sel_tgt, bus.exwb_bubble); end
        tick();
        vecs++; if (bus.ex_valid !== 1'b1 || retire_cnt !== 32'd1) begin errs++; $display("FAIL br_after valid/retire got %b/%0d exp 1/1", bus.ex_valid, retire_cnt); end
        clear_inputs();
    endtask

    task automatic test_back_to_back;
        do_reset();
        bus.imem_ack = 1'b1;
        tick();
        bus.ex_is_mem = 1'b1;
        bus.dmem_ack  = 1'b1;
        #1;
        vecs++; if (bus.pc_en !== 1'b1) begin errs++; $display("FAIL bb_both_ack pc_en got %b exp 1", bus.pc_en); end
        tick();
        bus.dmem_ack = 1'b0;
        #1;
        vecs++; if (bus.dmem_req !== 1'b1 || state !== RUN) begin errs++; $display("FAIL bb_next req/state got %b/%0d exp 1/0", bus.dmem_req, state); end
        tick();
        bus.ex_is_mem = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.dmem_ack  = 1'b1;
        tick();
        vecs++; if (state !== IWAIT) begin errs++; $display("FAIL bb_stray_state got %0d exp 1", state); end
        bus.ex_is_mem = 1'b1;
        bus.dmem_ack  = 1'b0;
        #1;
        vecs++; if (bus.dmem_req !== 1'b1) begin errs++; $display("FAIL bb_stray_ignored req got %b exp 1", bus.dmem_req); end
        clear_inputs();
    endtask

    task automatic test_timeout;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (state !== IWAIT || fault !== 1'b0) begin errs++; $display("FAIL to_wait[%0d] state/fault got %0d/%b exp 1/0", i, state, fault); end
        end
        tick();
        vecs++; if (state !== FAULT || fault !== 1'b1) begin errs++; $display("FAIL to_fault state/fault got %0d/%b exp 3/1", state, fault); end
        vecs++; if (stall_cnt !== 32'd4) begin errs++; $display("FAIL to_stall got %0d exp 4", stall_cnt); end
        vecs++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL to_imem_req got %b exp 0", bus.imem_req); end
        bus.imem_ack  = 1'b1;
        bus.ex_is_mem = 1'b1;
        #1;
        vecs++; if (bus.pc_en !== 1'b0 || bus.dmem_req !== 1'b0) begin errs++; $display("FAIL to_quiet pc_en/dmem_req got %b%b exp 00", bus.pc_en, bus.dmem_req); end
        tick(); tick(); tick();
        vecs++; if (stall_cnt !== 32'd4 || retire_cnt !== 32'd0 || state !== FAULT) begin errs++; $display("FAIL to_frozen stall/retire/state got %0d/%0d/%0d exp 4/0/3", stall_cnt, retire_cnt, state); end
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        vecs++; if (state !== RUN || fault !== 1'b0 || bus.imem_req !== 1'b1) begin errs++; $display("FAIL to_recover state/fault/imem_req got %0d/%b/%b exp 0/0/1", state, fault, bus.imem_req); end
        clear_inputs();
    endtask

    task automatic test_reset_dwait;
        do_reset();
        bus.imem_ack = 1'b1;
        tick();
        bus.ex_is_mem = 1'b1;
        tick();
        vecs++; if (state !== DWAIT) begin errs++; $display("FAIL rd_pre_state got %0d exp 2", state); end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++; if (state !== RUN || stall_cnt !== 32'd0 || bus.ex_valid !== 1'b0) begin errs++; $display("FAIL rd_async state/stall/ex_valid got %0d/%0d/%b exp 0/0/0", state, stall_cnt, bus.ex_valid); end
        vecs++; if (bus.dmem_req !== 1'b0 || bus.imem_req !== 1'b0) begin errs++; $display("FAIL rd_async reqs got %b%b exp 00", bus.dmem_req, bus.imem_req); end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_zero_wait();
        test_dmem_wait();
        test_dmem_early();
        test_branch();
        test_back_to_back();
        test_timeout();
        test_reset_dwait();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
